pipe_stage_chain: RTL and testbench

// - Parametrised chain of NUM_STAGES pipeline registers (IF/ID, ID/IE, IE/IM, IM/WB with defaults).
// - Each stage carries a payload word and a valid bit.
// - Per-stage stall and flush requests come from the hazard unit.
// - Replaces hand-coded per-stage register blocks in the CPU datapath.
// - Adds valid tracking, bubble insertion, upstream back-pressure and flush.

---
 rtl/pipe_stage_chain.sv | 118 +++++++++++
 tb/tb_pipe_stage_chain.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_chain.sv
//------------------------------------------------------------------------------
// Module   : pipe_stage_chain
// Brief    : Parametrised valid/payload pipeline register chain with stall and
//            flush handling. The optional perf counters are enabled by
//            PIPE_STAGE_CHAIN_PERF_CNT_EN.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module pipe_stage_chain #(
  parameter int PAYLOAD_WIDTH = 64,
  parameter int NUM_STAGES    = 4
) (
  input  logic                                i_clk,
  input  logic                                i_reset,
  input  logic                                i_in_valid,
  input  logic [PAYLOAD_WIDTH-1:0]            i_in_payload,
  output logic                                o_in_ready,
  input  logic [NUM_STAGES-1:0]               i_stall,
  input  logic [NUM_STAGES-1:0]               i_flush,
  output logic [NUM_STAGES-1:0]               o_stage_valid,
  output logic [NUM_STAGES*PAYLOAD_WIDTH-1:0] o_stage_payload,
  output logic                                o_out_valid,
  output logic [PAYLOAD_WIDTH-1:0]            o_out_payload,
  output logic [31:0]                         o_stall_cycles,
  output logic [31:0]                         o_flush_count
);

  if (NUM_STAGES < 2 || NUM_STAGES > 8) begin : g_bad_num_stages
    $error("pipe_stage_chain: NUM_STAGES must be in 2..8");
  end

  logic [NUM_STAGES-1:0] hold;

  for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
    logic                     stage_valid;
    logic [PAYLOAD_WIDTH-1:0] stage_payload;
    logic                     up_valid;
    logic [PAYLOAD_WIDTH-1:0] up_payload;
    logic                     up_frozen;

    assign hold[k] = |i_stall[NUM_STAGES-1:k];

    if (k == 0) begin : g_head
      assign up_valid   = i_in_valid;
      assign up_payload = i_in_payload;
      assign up_frozen  = 1'b0;
    end else begin : g_body
      assign up_valid   = o_stage_valid[k-1];
      assign up_payload = o_stage_payload[(k-1)*PAYLOAD_WIDTH +: PAYLOAD_WIDTH];
      // A flushed upstream stage is not holding anything, so its old word still drains down.
      assign up_frozen  = i_stall[k-1] & ~i_flush[k-1];
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
        stage_valid   <= 1'b0;
        stage_payload <= '0;
      end else if (i_flush[k]) begin
        stage_valid   <= 1'b0;
        stage_payload <= '0;
      end else if (hold[k]) begin
        stage_valid   <= stage_valid;
        stage_payload <= stage_payload;
      end else if (up_frozen) begin
        stage_valid   <= 1'b0;
        stage_payload <= '0;
      end else begin
        stage_valid   <= up_valid;
        stage_payload <= up_valid ? up_payload : '0;
      end
    end

    assign o_stage_valid[k]                                  = stage_valid;
    assign o_stage_payload[k*PAYLOAD_WIDTH +: PAYLOAD_WIDTH] = stage_payload;
  end

  assign o_in_ready    = ~hold[0];
  assign o_out_valid   = o_stage_valid[NUM_STAGES-1];
  assign o_out_payload = o_stage_payload[(NUM_STAGES-1)*PAYLOAD_WIDTH +: PAYLOAD_WIDTH];

`ifdef PIPE_STAGE_CHAIN_PERF_CNT_EN
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;
  logic [3:0]  kills;
  logic [32:0] flush_sum;

  always_comb begin
    kills = '0;
    for (int k = 0; k < NUM_STAGES; k++) begin
      kills = kills + 4'(i_flush[k] & o_stage_valid[k]);
    end
    flush_sum = {1'b0, flush_cnt} + 33'(kills);
  end

  // Both counters saturate rather than wrap.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (|i_stall && stall_cnt != 32'hFFFF_FFFF) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
      flush_cnt <= flush_sum[32] ? 32'hFFFF_FFFF : flush_sum[31:0];
    end
  end

  assign o_stall_cycles = stall_cnt;
  assign o_flush_count  = flush_cnt;
`else
  assign o_stall_cycles = 32'h0;
  assign o_flush_count  = 32'h0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipe_stage_chain.sv
//------------------------------------------------------------------------------
// Module   : tb_pipe_stage_chain
// Brief    : Scoreboard bench for pipe_stage_chain (default 4 x 64-bit stages).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_pipe_stage_chain;
  localparam int PW = 64;
  localparam int NS = 4;
`ifdef PIPE_STAGE_CHAIN_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic [PW-1:0]    in_payload = '0;
  logic             in_ready;
  logic [NS-1:0]    stall = '0;
  logic [NS-1:0]    flush = '0;
  logic [NS-1:0]    stage_valid;
  logic [NS*PW-1:0] stage_payload;
  logic             out_valid;
  logic [PW-1:0]    out_payload;
  logic [31:0]      stall_cycles;
  logic [31:0]      flush_count;

  pipe_stage_chain #(.PAYLOAD_WIDTH(PW), .NUM_STAGES(NS)) dut (
    .i_clk           (clk),
    .i_reset         (rst),
    .i_in_valid      (in_valid),
    .i_in_payload    (in_payload),
    .o_in_ready      (in_ready),
    .i_stall         (stall),
    .i_flush         (flush),
    .o_stage_valid   (stage_valid),
    .o_stage_payload (stage_payload),
    .o_out_valid     (out_valid),
    .o_out_payload   (out_payload),
    .o_stall_cycles  (stall_cycles),
    .o_flush_count   (flush_count)
  );

  always #5 clk = ~clk;

  int            n_vec = 0;
  int            n_bad = 0;
  int            outv_cycles = 0;
  bit            adv = 1'b0;
  logic [PW-1:0] exp_q[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [PW-1:0] stg(input int k);
    return stage_payload[k*PW +: PW];
  endfunction

  // The last stage takes a new word on every edge where it is not stalled.
  always @(posedge clk) adv = !stall[NS-1];

  always @(negedge clk) begin
    if (out_valid) outv_cycles++;
    if (!rst && adv && out_valid) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL unexpected_out: got 0x%0h, expected no output", out_payload);
      end else begin
        chk("out_payload", out_payload, exp_q.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [PW-1:0] v);
    in_valid   = 1'b1;
    in_payload = v;
    exp_q.push_back(v);
    step();
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0; in_payload = '0; stall = '0; flush = '0;
    repeat (n) step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0; in_payload = '0; stall = '0; flush = '0;
    step();
    rst = 1'b0;
    exp_q.delete();
    outv_cycles = 0;
  endtask

  task automatic check_counters(input string nm, input logic [31:0] s, input logic [31:0] f);
    chk({nm, "_stall_cycles"}, 64'(stall_cycles), PERF ? 64'(s) : 64'h0);
    chk({nm, "_flush_count"},  64'(flush_count),  PERF ? 64'(f) : 64'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    do_reset();
    chk("rst_stage_valid",   64'(stage_valid), 64'h0);
    chk("rst_stage_payload", 64'(|stage_payload), 64'h0);
    chk("rst_in_ready",      64'(in_ready), 64'h1);
    check_counters("rst", 32'd0, 32'd0);

    // Plain flow
    push(64'h11); push(64'h22); push(64'h33); push(64'h44);
    chk("flow_first_out", out_payload, 64'h11);
    idle(5);
    chk("flow_drained", 64'(exp_q.size()), 64'h0);
    chk("flow_valid_cycles", 64'(outv_cycles), 64'd4);

    // Load-use stall on stage 0
    do_reset();
    push(64'hA1); push(64'hB2);
    in_valid = 1'b1; in_payload = 64'hC3; stall = 4'b0001;
    #1;
    chk("lu_in_ready", 64'(in_ready), 64'h0);
    step();
    chk("lu_s0_valid",   64'(stage_valid[0]), 64'h1);
    chk("lu_s0_payload", stg(0), 64'hB2);
    chk("lu_s1_valid",   64'(stage_valid[1]), 64'h0);
    chk("lu_s1_payload", stg(1), 64'h0);
    chk("lu_s2_payload", stg(2), 64'hA1);
    stall = '0;
    push(64'hC3);
    idle(5);
    chk("lu_drained", 64'(exp_q.size()), 64'h0);
    check_counters("lu", 32'd1, 32'd0);

    // Branch flush of stages 0 and 1: the word in stage 0 is lost
    do_reset();
    push(64'h51); push(64'h52); push(64'h53); push(64'h54);
    void'(exp_q.pop_back());
    in_valid = 1'b0; in_payload = '0; flush = 4'b0011;
    step();
    flush = '0;
    chk("bf_valid_lo",   64'(stage_valid[1:0]), 64'h0);
    chk("bf_s2_payload", stg(2), 64'h53);
    chk("bf_s3_payload", stg(3), 64'h52);
    check_counters("bf", 32'd0, 32'd2);
    idle(4);
    chk("bf_drained", 64'(exp_q.size()), 64'h0);

    // Flush and stall on stage 2 together
    do_reset();
    push(64'h61); push(64'h62); push(64'h63); push(64'h64);
    in_valid = 1'b1; in_payload = 64'h65; stall = 4'b0100; flush = 4'b0100;
    #1;
    chk("fs_in_ready", 64'(in_ready), 64'h0);
    step();
    stall = '0; flush = '0;
    chk("fs_s2_valid",   64'(stage_valid[2]), 64'h0);
    chk("fs_s2_payload", stg(2), 64'h0);
    chk("fs_s0_payload", stg(0), 64'h64);
    chk("fs_s1_payload", stg(1), 64'h63);
    chk("fs_s3_payload", stg(3), 64'h62);
    idle(5);
    chk("fs_drained", 64'(exp_q.size()), 64'h0);
    check_counters("fs", 32'd1, 32'd1);

    // Stall on the last stage freezes everything
    do_reset();
    push(64'h71); push(64'h72); push(64'h73); push(64'h74);
    in_valid = 1'b1; in_payload = 64'h75; stall = 4'b1000;
    #1;
    chk("ls_in_ready", 64'(in_ready), 64'h0);
    step();
    chk("ls_out_hold1", out_payload, 64'h71);
    step();
    chk("ls_out_hold2", out_payload, 64'h71);
    chk("ls_out_valid", 64'(out_valid), 64'h1);
    idle(5);
    chk("ls_drained", 64'(exp_q.size()), 64'h0);
    check_counters("ls", 32'd2, 32'd0);

    // Asynchronous reset between edges
    do_reset();
    push(64'h81); push(64'h82); push(64'h83); push(64'h84);
    chk("ar_full", 64'(stage_valid), 64'hF);
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("ar_stage_valid",   64'(stage_valid), 64'h0);
    chk("ar_out_payload",   out_payload, 64'h0);
    chk("ar_stage_payload", 64'(|stage_payload), 64'h0);
    exp_q.delete();
    rst = 1'b0;
    idle(2);
    chk("ar_out_valid", 64'(out_valid), 64'h0);

    // Stall counter saturation
    do_reset();
`ifdef PIPE_STAGE_CHAIN_PERF_CNT_EN
    force dut.stall_cnt = 32'hFFFF_FFFE;
    #1;
    release dut.stall_cnt;
    chk("sat_preload", 64'(stall_cycles), 64'hFFFF_FFFE);
`endif
    stall = 4'b0001;
    repeat (3) step();
    stall = '0;
    chk("sat_stall_cycles", 64'(stall_cycles), PERF ? 64'hFFFF_FFFF : 64'h0);
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

`default_nettype wire
